// File: rtl/enemy_motion.sv
// Per-enemy chase / hit / death / respawn controller, advanced once per frame_clk edge.
// Outputs are registered and feed the walk-animation stepper and the score logic.
module enemy_motion #(
  parameter logic [8:0] SPAWN_X     = 9'd16,
  parameter logic [8:0] SPAWN_Y     = 9'd16,
  parameter int         X_MIN       = 0,
  parameter int         X_MAX       = 463,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 463,
  parameter int         STEP        = 2,
  parameter int         MOVE_DIV    = 2,
  parameter int         SPAWN_DELAY = 32,
  parameter int         MAX_HP      = 3,
  parameter int         KNOCKBACK   = 8,
  parameter int         HURT_FRAMES = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Hit,
  input  logic [1:0] Hit_Dir,
  output logic [8:0] Obj_X_Pos,
  output logic [8:0] Obj_Y_Pos,
  output logic [8:0] Obj_X_Motion,
  output logic [8:0] Obj_Y_Motion,
  output logic [1:0] Obj_Dir,
  output logic       Alive,
  output logic       Kill,
  output logic [2:0] HP,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_SPAWN = 2'd0;
  localparam logic [1:0] S_CHASE = 2'd1;
  localparam logic [1:0] S_HURT  = 2'd2;
  localparam logic [1:0] S_DEAD  = 2'd3;

  localparam logic [15:0] SPAWN_RELOAD = 16'(SPAWN_DELAY - 1);
  localparam logic [15:0] HURT_RELOAD  = 16'(HURT_FRAMES - 1);
  localparam logic [15:0] DIV_LAST     = 16'(MOVE_DIV - 1);
  localparam logic [2:0]  HP_INIT      = 3'(MAX_HP);

  localparam logic signed [9:0] STEP_S = 10'(STEP);
  localparam logic signed [9:0] KB_S   = 10'(KNOCKBACK);
  localparam logic signed [9:0] IDLE_S = 10'sd2;
  localparam logic signed [9:0] XMIN_S = 10'(X_MIN);
  localparam logic signed [9:0] XMAX_S = 10'(X_MAX);
  localparam logic signed [9:0] YMIN_S = 10'(Y_MIN);
  localparam logic signed [9:0] YMAX_S = 10'(Y_MAX);

  logic [1:0]  state;
  logic [15:0] spawn_cnt;
  logic [15:0] hurt_cnt;
  logic [15:0] div;

  function automatic logic signed [9:0] abs10(input logic signed [9:0] v);
    return v[9] ? -v : v;
  endfunction

  function automatic logic signed [9:0] step_toward(input logic signed [9:0] d);
    logic signed [9:0] m;
    m = (abs10(d) > STEP_S) ? STEP_S : abs10(d);
    return d[9] ? -m : m;
  endfunction

  function automatic logic [8:0] clamp(input logic signed [9:0] v,
                                       input logic signed [9:0] lo,
                                       input logic signed [9:0] hi);
    if (v < lo) return lo[8:0];
    if (v > hi) return hi[8:0];
    return v[8:0];
  endfunction

  logic signed [9:0] cur_x, cur_y, dx, dy, mx, my, kx, ky;
  logic              idle_zone;
  logic [1:0]        move_dir;

  // Sums are kept 10-bit signed so an underflow below zero clamps instead of wrapping.
  always_comb begin
    cur_x     = $signed({1'b0, Obj_X_Pos});
    cur_y     = $signed({1'b0, Obj_Y_Pos});
    dx        = $signed({1'b0, Player_X}) - cur_x;
    dy        = $signed({1'b0, Player_Y}) - cur_y;
    idle_zone = (abs10(dx) <= IDLE_S) && (abs10(dy) <= IDLE_S);
    mx        = idle_zone ? '0 : step_toward(dx);
    my        = idle_zone ? '0 : step_toward(dy);
    if (abs10(mx) >= abs10(my)) move_dir = mx[9] ? 2'd3 : 2'd1;
    else                        move_dir = my[9] ? 2'd0 : 2'd2;
    kx = cur_x;
    ky = cur_y;
    case (Hit_Dir)
      2'd0:    ky = cur_y - KB_S;
      2'd1:    kx = cur_x + KB_S;
      2'd2:    ky = cur_y + KB_S;
      default: kx = cur_x - KB_S;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_SPAWN;
      Obj_X_Pos    <= SPAWN_X;
      Obj_Y_Pos    <= SPAWN_Y;
      Obj_X_Motion <= '0;
      Obj_Y_Motion <= '0;
      Obj_Dir      <= 2'd2;
      Alive        <= 1'b0;
      Kill         <= 1'b0;
      HP           <= HP_INIT;
      spawn_cnt    <= SPAWN_RELOAD;
      div          <= '0;
      hurt_cnt     <= '0;
    end else if (!Enable) begin
      Kill <= 1'b0;
    end else begin
      Kill <= 1'b0;
      case (state)
        S_SPAWN: begin
          Alive <= 1'b0;
          if (spawn_cnt == '0) begin
            state <= S_CHASE;
            Alive <= 1'b1;
            div   <= '0;
          end else begin
            spawn_cnt <= spawn_cnt - 16'd1;
          end
        end
        S_CHASE: begin
          if (Hit) begin
            Obj_X_Motion <= '0;
            Obj_Y_Motion <= '0;
            if (HP == 3'd1) begin
              HP    <= '0;
              state <= S_DEAD;
              Kill  <= 1'b1;
              Alive <= 1'b0;
            end else begin
              HP        <= HP - 3'd1;
              Obj_X_Pos <= clamp(kx, XMIN_S, XMAX_S);
              Obj_Y_Pos <= clamp(ky, YMIN_S, YMAX_S);
              hurt_cnt  <= HURT_RELOAD;
              state     <= S_HURT;
            end
          end else begin
            div <= (div == DIV_LAST) ? '0 : div + 16'd1;
            if (div == '0) begin
              Obj_X_Pos    <= clamp(cur_x + mx, XMIN_S, XMAX_S);
              Obj_Y_Pos    <= clamp(cur_y + my, YMIN_S, YMAX_S);
              Obj_X_Motion <= mx[8:0];
              Obj_Y_Motion <= my[8:0];
              if (mx != '0 || my != '0) Obj_Dir <= move_dir;
            end else begin
              Obj_X_Motion <= '0;
              Obj_Y_Motion <= '0;
            end
          end
        end
        S_HURT: begin
          Obj_X_Motion <= '0;
          Obj_Y_Motion <= '0;
          if (hurt_cnt == '0) begin
            state <= S_CHASE;
            div   <= '0;
          end else begin
            hurt_cnt <= hurt_cnt - 16'd1;
          end
        end
        default: begin
          state        <= S_SPAWN;
          Obj_X_Pos    <= SPAWN_X;
          Obj_Y_Pos    <= SPAWN_Y;
          Obj_X_Motion <= '0;
          Obj_Y_Motion <= '0;
          Alive        <= 1'b0;
          HP           <= HP_INIT;
          spawn_cnt    <= SPAWN_RELOAD;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/enemy_motion.md
Name: enemy_motion

Overview:
Per-enemy movement and life-cycle controller for boxhead. It runs once per frame and produces the enemy position and motion that the enemy walk-animation stepper consumes (Obj_X_Pos, Obj_Y_Pos, Obj_X_Motion, Obj_Y_Motion). It chases the player, takes bullet hits with knockback, dies, and respawns after a delay. One instance is used per enemy.

Parameters:
SPAWN_X, 9'd16, respawn/reset X position
SPAWN_Y, 9'd16, respawn/reset Y position
X_MIN / X_MAX, 0 / 463, inclusive X clamp bounds
Y_MIN / Y_MAX, 0 / 463, inclusive Y clamp bounds
STEP, 2, pixels per move per axis (1..15)
MOVE_DIV, 2, move on one of every MOVE_DIV frames (>=1)
SPAWN_DELAY, 32, frames spent invisible before chasing (>=1)
MAX_HP, 3, hit points on spawn (1..7)
KNOCKBACK, 8, displacement applied on a non-lethal hit
HURT_FRAMES, 6, stun/invulnerability length in frames (>=1)

Ports:
frame_clk  in  1  frame clock; all state advances on its rising edge
Reset  in  1  asynchronous, active-high
Enable  in  1  0 freezes all state (game paused)
Player_X, Player_Y  in  9  player position
Hit  in  1  bullet hit on this enemy, sampled per frame
Hit_Dir  in  2  bullet travel direction: 0 up, 1 right, 2 down, 3 left
Obj_X_Pos, Obj_Y_Pos  out  9  enemy position (registered)
Obj_X_Motion, Obj_Y_Motion  out  9  last applied displacement, two's complement (registered)
Obj_Dir  out  2  facing, same encoding as Hit_Dir
Alive  out  1  enemy visible and collidable
Kill  out  1  one-frame pulse on death, used by the score logic
HP  out  3  current hit points

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, independent of frame_clk, and can arrive mid-operation. Reset values: state S_SPAWN; pos = (SPAWN_X, SPAWN_Y); motion = 0; Obj_Dir = 2; Alive = 0; Kill = 0; HP = MAX_HP; spawn counter = SPAWN_DELAY-1; divider = 0; hurt counter = 0.
- Enable = 0: all registers hold their values, Hit is ignored, and Kill is forced to 0.
- S_SPAWN:
  - Alive = 0.
  - The counter decrements each frame. At 0, go to S_CHASE with Alive = 1 and divider = 0.
  - Hit is ignored.
- S_CHASE:
  - A move frame occurs when divider == 0. The divider counts 0..MOVE_DIV-1 and wraps.
  - On a move frame, dx = Player_X - X, dy = Player_Y - Y, computed as 10-bit signed values.
  - Dead zone: if |dx| <= 2 and |dy| <= 2, motion = 0. This matches the stepper's idle window.
  - Otherwise, per axis: motion = sign(d) * min(|d|, STEP). There is no overshoot.
  - pos <= clamp(pos + motion) to [MIN, MAX]. The sum is computed 10-bit signed so that underflow below 0 clamps to MIN.
  - Motion outputs hold the computed motion on a move frame and 0 on every other frame.
  - Obj_Dir follows the axis with the larger |motion|, horizontal on a tie. It is unchanged when motion is 0.
  - Hit = 1 takes priority over movement that frame:
    - If HP == 1: HP = 0, go to S_DEAD.
    - Otherwise: HP decrements; pos is displaced by KNOCKBACK in Hit_Dir (clamped); motion = 0; hurt counter = HURT_FRAMES-1; go to S_HURT.
- S_HURT:
  - No chase movement; motion = 0.
  - Hit is ignored (invulnerable).
  - The counter decrements each frame. At 0, go to S_CHASE with divider = 0.
- S_DEAD:
  - Lasts exactly one frame, with Kill = 1 and Alive = 0.
  - Next frame: go to S_SPAWN, reload pos to spawn, HP = MAX_HP, spawn counter = SPAWN_DELAY-1, motion = 0.
- Kill is 1 only while in S_DEAD. There are no other pulses.
- All outputs are registered. A change in Player_X/Y affects position at the next move edge.

Test Plan:
- Reset pulsed between clock edges while in S_CHASE at (200,200) -> outputs become (16,16), Alive = 0, HP = 3 immediately; after release, Alive = 1 after exactly 32 frame_clk edges.
- Chase: enter S_CHASE at (16,16), Player = (100,16), Enable = 1 -> moves on chase edges 1,3,5,7,9; after 10 edges pos = (26,16); motion alternates (+2,0)/(0,0); Obj_Dir = 1.
- Dead zone and no-overshoot: pos (16,16), Player (19,16) -> one move to (18,16), then motion 0 forever; Player (17,50) -> Y motion +2 per move and X motion +1 once.
- Knockback clamp: pos (4,50), Hit = 1, Hit_Dir = 3 -> HP = 2, pos = (0,50), S_HURT for 6 frames; a second Hit at hurt frame 3 leaves HP = 2; chase resumes on frame 7.
- Death/respawn: three hits spaced by more than 6 frames -> third hit gives one-frame Kill = 1 and Alive = 0; next frame pos = (16,16), HP = 3; Alive returns 32 frames later.
- Pause: Enable = 0 for 10 frames mid-chase with Hit pulses -> pos, HP, divider and state unchanged; Kill = 0; motion resumes with the same divider phase when Enable returns to 1.
